// File: rtl/i2c_slave_tx_shifter_if.sv
// Transmit-byte source bundle between user side, byte-write stage and shifter.
// Latency: none (wires only).
// Backpressure: tx_ready from the shifter throttles the tx_valid/tx_data offer.
interface i2c_slave_tx_shifter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       start;
    logic       abort;
    logic       load;
    logic       data;
    logic       byte_sent;
    logic       underrun;
    logic       busy;

    modport master (
        output tx_data, tx_valid, start, abort, load,
        input  tx_ready, data, byte_sent, underrun, busy
    );

    modport slave (
        input  tx_data, tx_valid, start, abort, load,
        output tx_ready, data, byte_sent, underrun, busy
    );
endinterface

// File: rtl/i2c_slave_tx_shifter.sv
// Serialises transmit bytes for the I2C slave byte-write stage, one-byte holding buffer.
// Latency: data/busy/byte_sent/underrun reflect a load/start/abort one clock later.
// Backpressure: tx_ready = ~hold_valid; when empty at a reload a live offer is bypassed, else IDLE_BYTE.
module i2c_slave_tx_shifter #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF,
    parameter bit         MSB_FIRST = 1'b1
) (
    input logic                   clock,
    input logic                   reset,
    i2c_slave_tx_shifter_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0] state_q;
    logic [7:0] hold_q;
    logic       hold_valid;
    logic [7:0] shift_q;
    logic [2:0] cnt;
    logic       byte_sent_q;
    logic       underrun_q;

    logic       active;
    logic       last_bit;
    logic       do_start;
    logic       end_of_byte;
    logic       do_reload;
    logic       do_shift;
    logic       accept;
    logic [7:0] shifted;
    logic [7:0] reload_byte;

    assign active   = (state_q == ST_ACTIVE);
    assign last_bit = (cnt == 3'd7);

    // abort beats start; start while ACTIVE behaves as abort+start, so it also beats load
    assign do_start    = bus.start && !bus.abort;
    assign end_of_byte = active && bus.load && last_bit && !bus.abort && !bus.start;
    assign do_reload   = do_start || end_of_byte;
    assign do_shift    = active && bus.load && !last_bit && !bus.abort && !bus.start;

    assign bus.tx_ready = ~hold_valid;
    assign accept       = bus.tx_valid && ~hold_valid;

    // Bits move toward the output end; vacated bits fill with 1 so SDA stays released
    assign shifted = MSB_FIRST ? {shift_q[6:0], 1'b1} : {1'b1, shift_q[7:1]};

    // Reload source priority: buffered byte, then a live offer (bypass), then idle pattern
    assign reload_byte = hold_valid   ? hold_q  :
                         bus.tx_valid ? bus.tx_data : IDLE_BYTE;

    // Output bit comes straight from state registers; forced high outside a transaction
    assign bus.data      = active ? (MSB_FIRST ? shift_q[7] : shift_q[0]) : 1'b1;
    assign bus.busy      = active;
    assign bus.byte_sent = byte_sent_q;
    assign bus.underrun  = underrun_q;

    // Holding register: drained by a reload, filled by a handshake that is not bypassed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q     <= 8'h00;
            hold_valid <= 1'b0;
        end else if (do_reload && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (accept && !do_reload) begin
            hold_q     <= bus.tx_data;
            hold_valid <= 1'b1;
        end
    end

    // Transaction state, shift register and bit counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= IDLE_BYTE;
            cnt     <= 3'd0;
        end else if (do_reload) begin
            state_q <= ST_ACTIVE;
            shift_q <= reload_byte;
            cnt     <= 3'd0;
        end else if (bus.abort) begin
            // partial byte is dropped; the holding register is left alone
            state_q <= ST_IDLE;
            shift_q <= IDLE_BYTE;
            cnt     <= 3'd0;
        end else if (do_shift) begin
            shift_q <= shifted;
            cnt     <= cnt + 3'd1;
        end
    end

    // One-cycle status pulses for the byte just completed and for an empty reload
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_sent_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            byte_sent_q <= end_of_byte;
            underrun_q  <= do_reload && !hold_valid && !bus.tx_valid;
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx_shifter.sv
// Directed bench for i2c_slave_tx_shifter with a queue-based scoreboard.
// Stimulus pushes expected data/busy per load/start/abort and expected pulses.
// A monitor pops and compares on the falling edge after each DUT response.
module tb_i2c_slave_tx_shifter;

    logic clock;
    logic reset;

    i2c_slave_tx_shifter_if bus ();

    i2c_slave_tx_shifter #(
        .IDLE_BYTE (8'hFF),
        .MSB_FIRST (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic d;
        logic b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ev_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Monitor: compare after every cycle that carried a load/start/abort, and on every pulse
    initial begin : monitor
        logic issued;
        exp_t e;
        logic [7:0] ev;
        forever begin
            @(posedge clock);
            issued = !reset && (bus.load || bus.start || bus.abort);
            @(negedge clock);
            if (issued) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", {7'd0, bus.data}, {7'd0, e.d});
                    chk("busy", {7'd0, bus.busy}, {7'd0, e.b});
                end
            end
            if (bus.byte_sent === 1'b1) begin
                ev = (ev_q.size() != 0) ? ev_q.pop_front() : 8'h00;
                chk("byte_sent_pulse", ev, "B");
            end
            if (bus.underrun === 1'b1) begin
                ev = (ev_q.size() != 0) ? ev_q.pop_front() : 8'h00;
                chk("underrun_pulse", ev, "U");
            end
        end
    end

    // One clock of stimulus; expected data/busy queued when the monitor will compare
    task automatic cyc(input logic ld, input logic st, input logic ab,
                       input logic tv, input logic [7:0] td,
                       input logic exp_d, input logic exp_b);
        exp_t e;
        if (ld || st || ab) begin
            e.d = exp_d;
            e.b = exp_b;
            exp_q.push_back(e);
        end
        bus.load     = ld;
        bus.start    = st;
        bus.abort    = ab;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        @(posedge clock);
        #1;
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
    endtask

    task automatic offer(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, b, 1'b1, 1'b0);
    endtask

    task automatic ld(input logic exp_d);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp_d, 1'b1);
    endtask

    task automatic ld_tx(input logic exp_d, input logic [7:0] td);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, td, exp_d, 1'b1);
    endtask

    task automatic strt(input logic exp_d);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, exp_d, 1'b1);
    endtask

    task automatic abrt();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Loads 1..7 of a byte: each exposes the next lower bit
    task automatic seven_loads(input logic [7:0] b);
        for (int i = 0; i < 7; i++) ld(b[6-i]);
    endtask

    initial begin : stim
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_data",      {7'd0, bus.data},      8'd1);
        chk("rst_busy",      {7'd0, bus.busy},      8'd0);
        chk("rst_tx_ready",  {7'd0, bus.tx_ready},  8'd1);
        chk("rst_byte_sent", {7'd0, bus.byte_sent}, 8'd0);
        chk("rst_underrun",  {7'd0, bus.underrun},  8'd0);

        // Buffered byte A5: 1,0,1,0,0,1,0,1 then idle byte with empty buffer
        offer(8'hA5);
        chk("a5_tx_ready_full", {7'd0, bus.tx_ready}, 8'd0);
        strt(1'b1);
        chk("a5_tx_ready_after_start", {7'd0, bus.tx_ready}, 8'd1);
        seven_loads(8'hA5);
        ev_q.push_back("B");
        ev_q.push_back("U");
        ld(1'b1);
        abrt();

        // Bypass: 3C offered during start, goes straight to shifter
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        chk("bypass_hold_empty", {7'd0, bus.tx_ready}, 8'd1);
        seven_loads(8'h3C);
        // abort with load at the last bit: no byte_sent
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back: 81, then 7E buffered during the 7th load, then FF buffered
        offer(8'h81);
        strt(1'b1);
        for (int i = 0; i < 6; i++) ld(1'b0);
        ld_tx(1'b1, 8'h7E);
        ev_q.push_back("B");
        ld(1'b0);
        ld(1'b1);
        ld(1'b1);
        ld_tx(1'b1, 8'hFF);
        ld(1'b1);
        ld(1'b1);
        ld(1'b1);
        ld(1'b0);
        ev_q.push_back("B");
        ld(1'b1);
        abrt();

        // Underrun at start, 55 arrives mid-byte and is used at the next reload
        ev_q.push_back("U");
        strt(1'b1);
        ld(1'b1);
        ld(1'b1);
        ld_tx(1'b1, 8'h55);
        chk("ur_hold_filled", {7'd0, bus.tx_ready}, 8'd0);
        for (int i = 0; i < 4; i++) ld(1'b1);
        ev_q.push_back("B");
        ld(1'b0);
        seven_loads(8'h55);
        abrt();

        // Abort after 3 loads of 0F; buffered C3 survives into the next transaction
        offer(8'h0F);
        strt(1'b0);
        ld(1'b0);
        ld(1'b0);
        ld(1'b0);
        offer(8'hC3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("abort_keeps_hold", {7'd0, bus.tx_ready}, 8'd0);
        // load while idle is ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        strt(1'b1);
        chk("c3_hold_drained", {7'd0, bus.tx_ready}, 8'd1);
        seven_loads(8'hC3);
        // start while active with nothing available: restart with idle byte
        ev_q.push_back("U");
        strt(1'b1);
        abrt();

        // Asynchronous reset mid-transfer discards the buffered byte
        offer(8'h96);
        strt(1'b1);
        ld(1'b0);
        offer(8'h5A);
        chk("pre_reset_hold_full", {7'd0, bus.tx_ready}, 8'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_data", {7'd0, bus.data}, 8'd1);
        chk("async_rst_busy", {7'd0, bus.busy}, 8'd0);
        reset = 1'b0;
        #2;
        chk("post_rst_tx_ready", {7'd0, bus.tx_ready}, 8'd1);
        @(posedge clock);
        #1;
        ev_q.push_back("U");
        strt(1'b1);
        abrt();

        repeat (4) @(posedge clock);
        #1;
        chk("exp_queue_drained",   exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        chk("event_queue_drained", ev_q.size()  == 0 ? 8'd1 : 8'd0, 8'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
